// File: rtl/agc_arith_pkg.sv
// Shared arithmetic definitions for the AGC ALU: word width, divider FSM states,
// and one's-complement magnitude/sign helpers.
package agc_arith_pkg;

  localparam int NUM_BIT = 15;
  localparam int CNT_W   = $clog2(NUM_BIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic [NUM_BIT-2:0] oc_mag(input logic [NUM_BIT-1:0] word);
    return word[NUM_BIT-1] ? ~word[NUM_BIT-2:0] : word[NUM_BIT-2:0];
  endfunction

  function automatic logic [2*NUM_BIT-2:0] oc_mag_dw(input logic [2*NUM_BIT-1:0] word);
    return word[2*NUM_BIT-1] ? ~word[2*NUM_BIT-2:0] : word[2*NUM_BIT-2:0];
  endfunction

  // Negative zero is produced deliberately when the sign is set on a zero magnitude.
  function automatic logic [NUM_BIT-1:0] oc_apply_sign(input logic [NUM_BIT-2:0] mag,
                                                       input logic sign);
    return sign ? ~{1'b0, mag} : {1'b0, mag};
  endfunction

endpackage

// File: rtl/ones_comp_seq_div_if.sv
// Operand/result handshake bundle for the sequential one's-complement divider.
interface ones_comp_seq_div_if;
  import agc_arith_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [2*NUM_BIT-1:0]   numer;
  logic [NUM_BIT-1:0]     denom;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_BIT-1:0]     quot;
  logic [NUM_BIT-1:0]     remain;
  logic                   div_by_zero;
  logic                   overflow_flag;

  modport master (
    output in_valid, numer, denom, out_ready,
    input  in_ready, out_valid, quot, remain, div_by_zero, overflow_flag
  );

  modport slave (
    input  in_valid, numer, denom, out_ready,
    output in_ready, out_valid, quot, remain, div_by_zero, overflow_flag
  );

endinterface

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_restore_step
  import agc_arith_pkg::*;
(
  input  logic [NUM_BIT-1:0] p,
  input  logic               next_bit,
  input  logic [NUM_BIT-2:0] dmag,
  output logic [NUM_BIT-1:0] p_next,
  output logic               qbit
);

  logic [NUM_BIT:0]   t;
  logic [NUM_BIT-1:0] diff;

  assign t    = {p, next_bit};
  assign qbit = (t >= {2'b00, dmag});
  // With p < dmag on entry, t < 2*dmag, so the difference always fits in the low NUM_BIT bits.
  assign diff   = t[NUM_BIT-1:0] - {1'b0, dmag};
  assign p_next = qbit ? diff : t[NUM_BIT-1:0];

endmodule

// File: rtl/ones_comp_seq_div.sv
// Sequential restoring divider: 2*NUM_BIT one's-complement dividend by NUM_BIT divisor,
// one quotient bit per clock, valid/ready on both sides, results held until consumed.
module ones_comp_seq_div
  import agc_arith_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  ones_comp_seq_div_if.slave  bus
);

  localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(NUM_BIT-2);
  localparam logic [NUM_BIT-2:0] MAG_MAX   = '1;

  div_state_t           state;
  logic [CNT_W-1:0]     count;
  logic [NUM_BIT-1:0]   p_reg;
  logic [NUM_BIT-2:0]   shreg;
  logic [NUM_BIT-2:0]   dmag_reg;
  logic                 qsign;
  logic                 rsign;
  logic                 out_valid_r;
  logic [NUM_BIT-1:0]   quot_r;
  logic [NUM_BIT-1:0]   remain_r;
  logic                 dbz_r;
  logic                 ovf_r;

  logic [2*NUM_BIT-2:0] nmag_in;
  logic [NUM_BIT-2:0]   dmag_in;
  logic [NUM_BIT-1:0]   p_in;
  logic                 dbz_in;
  logic                 ovf_in;
  logic [NUM_BIT-1:0]   p_next;
  logic                 qbit;

  assign nmag_in = oc_mag_dw(bus.numer);
  assign dmag_in = oc_mag(bus.denom);
  assign p_in    = nmag_in[2*NUM_BIT-2:NUM_BIT-1];
  assign dbz_in  = (dmag_in == '0);
  assign ovf_in  = !dbz_in && (p_in >= {1'b0, dmag_in});

  // The shift register feeds dividend bits out of its MSB while quotient bits fill its LSB.
  div_restore_step u_step (
    .p        (p_reg),
    .next_bit (shreg[NUM_BIT-2]),
    .dmag     (dmag_reg),
    .p_next   (p_next),
    .qbit     (qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      p_reg       <= '0;
      shreg       <= '0;
      dmag_reg    <= '0;
      qsign       <= 1'b0;
      rsign       <= 1'b0;
      out_valid_r <= 1'b0;
      quot_r      <= '0;
      remain_r    <= '0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            p_reg    <= p_in;
            shreg    <= nmag_in[NUM_BIT-2:0];
            dmag_reg <= dmag_in;
            qsign    <= bus.numer[2*NUM_BIT-1] ^ bus.denom[NUM_BIT-1];
            rsign    <= bus.numer[2*NUM_BIT-1];
            count    <= '0;
            dbz_r    <= dbz_in;
            ovf_r    <= ovf_in;
            state    <= (dbz_in || ovf_in) ? DONE : CALC;
          end
        end
        CALC: begin
          p_reg <= p_next;
          shreg <= {shreg[NUM_BIT-3:0], qbit};
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            state <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle registers the signed results; later cycles wait for the consumer.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            if (dbz_r || ovf_r) begin
              quot_r   <= oc_apply_sign(MAG_MAX, qsign);
              remain_r <= '0;
            end else begin
              quot_r   <= oc_apply_sign(shreg, qsign);
              remain_r <= oc_apply_sign(p_reg[NUM_BIT-2:0], rsign);
            end
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (state == IDLE);
  assign bus.out_valid     = out_valid_r;
  assign bus.quot          = quot_r;
  assign bus.remain        = remain_r;
  assign bus.div_by_zero   = dbz_r;
  assign bus.overflow_flag = ovf_r;

endmodule

// File: tb/tb_ones_comp_seq_div.sv
// Directed bench for ones_comp_seq_div with hand-computed quotients, remainders and latencies.
module tb_ones_comp_seq_div;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ones_comp_seq_div_if bus ();

  ones_comp_seq_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation for a single cycle; caller has already checked in_ready.
  task automatic start_op(input logic [29:0] n, input logic [14:0] d);
    chk("in_ready_before_op", {31'd0, bus.in_ready}, 32'd1);
    bus.numer    = n;
    bus.denom    = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [29:0] n, input logic [14:0] d,
                        input logic [14:0] q, input logic [14:0] r,
                        input logic dbz, input logic ovf, input int lat);
    int cyc;
    start_op(n, d);
    wait_valid(cyc);
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_quot"}, {17'd0, bus.quot}, {17'd0, q});
    chk({tag, "_remain"}, {17'd0, bus.remain}, {17'd0, r});
    chk({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, dbz});
    chk({tag, "_ovf"}, {31'd0, bus.overflow_flag}, {31'd0, ovf});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int cyc;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.numer     = '0;
    bus.denom     = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_quot", {17'd0, bus.quot}, 32'd0);
    chk("rst_remain", {17'd0, bus.remain}, 32'd0);
    chk("rst_flags", {30'd0, bus.div_by_zero, bus.overflow_flag}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("pos_pos",   30'd100,        15'd7,      15'd14,     15'd2,      1'b0, 1'b0, 15);
    run_op("neg_pos",   ~30'd100,       15'd7,      15'h7FF1,   15'h7FFD,   1'b0, 1'b0, 15);
    run_op("pos_neg",   30'd100,        ~15'd7,     15'h7FF1,   15'd2,      1'b0, 1'b0, 15);
    run_op("neg_neg",   ~30'd100,       ~15'd7,     15'd14,     15'h7FFD,   1'b0, 1'b0, 15);
    run_op("negzero",   30'h3FFFFFFF,   15'd7,      15'h7FFF,   15'h7FFF,   1'b0, 1'b0, 15);
    run_op("max_quot",  30'd114687,     15'd7,      15'h3FFF,   15'd6,      1'b0, 1'b0, 15);
    run_op("dbz_negz",  30'd100,        15'h7FFF,   15'h4000,   15'd0,      1'b1, 1'b0, 1);
    run_op("dbz_posz",  ~30'd100,       15'd0,      15'h4000,   15'd0,      1'b1, 1'b0, 1);
    run_op("ovf_hi",    {15'd7, 15'd0}, 15'd7,      15'h3FFF,   15'd0,      1'b0, 1'b1, 1);
    run_op("ovf_edge",  30'd114688,     15'd7,      15'h3FFF,   15'd0,      1'b0, 1'b1, 1);
    run_op("clr_flags", 30'd21,         15'd3,      15'd7,      15'd0,      1'b0, 1'b0, 15);

    // Result held while the consumer stalls.
    start_op(30'd100, 15'd7);
    wait_valid(cyc);
    chk("hold_latency", cyc, 32'd15);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_quot", {17'd0, bus.quot}, 32'd14);
      chk("hold_remain", {17'd0, bus.remain}, 32'd2);
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("release_valid", {31'd0, bus.out_valid}, 32'd0);

    // Reset in the middle of a calculation aborts it.
    start_op(30'd100, 15'd7);
    for (int i = 0; i < 6; i++) tick();
    chk("mid_busy", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_quot", {17'd0, bus.quot}, 32'd0);
    rst_n = 1'b1;
    tick();
    run_op("after_rst", 30'd49, 15'd7, 15'd7, 15'd0, 1'b0, 1'b0, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
